// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register map, STATUS bit
// positions and the TX/RX state encodings.
package uart_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVIDER = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int ST_TX_BUSY    = 0;
   localparam int ST_RX_VALID   = 1;
   localparam int ST_TX_FULL    = 2;
   localparam int ST_RX_FULL    = 3;
   localparam int ST_RX_OVERRUN = 4;
   localparam int ST_FRAME_ERR  = 5;
   localparam int ST_TX_OVF     = 6;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output. A pop frees its
// entry in the same cycle, so push is accepted on a full FIFO when popping.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/peri_uart_fifo.sv
// UART peripheral with TX/RX FIFOs and a 4-register bus interface.
// Optional RTS/CTS flow control is enabled by defining UART_FLOW_CTRL_EN.
module peri_uart_fifo
   import uart_pkg::*;
#(
   parameter int TX_DEPTH  = 8,
   parameter int RX_DEPTH  = 8,
   parameter int DIV_W     = 12,
   parameter int DIV_RESET = 555
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [1:0]  reg_sel,
   input  logic [1:0]  write_n,
   input  logic [1:0]  read_n,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        uart_rxd,
   output logic        uart_txd,
`ifdef UART_FLOW_CTRL_EN
   output logic        uart_rts,
   input  logic        uart_cts,
`endif
   output logic        irq
);
   localparam int TXCW = $clog2(TX_DEPTH) + 1;
   localparam int RXCW = $clog2(RX_DEPTH) + 1;

   logic             wr, rd;
   logic [DIV_W-1:0] divider;
   logic             tx_ie, rx_ie;
   logic             tx_ovf, frame_err, rx_overrun;

   logic             tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_can_start;
   logic [7:0]       tx_dout;
   logic [TXCW-1:0]  tx_count;
   logic             rx_push, rx_pop, rx_full, rx_empty, rx_valid;
   logic [7:0]       rx_dout;
   logic [RXCW-1:0]  rx_count;
   logic [6:0]       status;
   logic             cts_ok;

   assign wr = (write_n != 2'b11);
   assign rd = (read_n != 2'b11);

   // ---------------- flow control ----------------
`ifdef UART_FLOW_CTRL_EN
   logic cts_s1, cts_s2;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cts_s1 <= 1'b0;
         cts_s2 <= 1'b0;
      end else begin
         cts_s1 <= uart_cts;
         cts_s2 <= cts_s1;
      end
   end
   assign cts_ok   = ~cts_s2;
   assign uart_rts = (rx_count >= RXCW'(RX_DEPTH - 1));
   logic unused;
   assign unused = ^{tx_count, data_in[31:DIV_W]};
`else
   assign cts_ok = 1'b1;
   logic unused;
   assign unused = ^{tx_count, rx_count, data_in[31:DIV_W]};
`endif

   // ---------------- FIFOs ----------------
   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rstn(rstn), .push(tx_push), .din(data_in[7:0]), .pop(tx_pop),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   // ---------------- TX ----------------
   tx_state_e        tx_state;
   logic [DIV_W-1:0] tx_cnt, tx_div;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_sh;
   logic             tx_tick;

   assign tx_tick      = (tx_cnt == tx_div);
   assign tx_can_start = ~tx_empty & cts_ok;
   assign tx_pop       = tx_can_start &
                         ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tick));
   assign tx_push      = wr && (reg_sel == REG_DATA);
   assign tx_busy      = ~tx_empty | (tx_state != TX_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         uart_txd <= 1'b1;
      end else begin
         // tx_pop already folds in the "starting a frame" condition
         if (tx_pop) begin
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_div   <= divider;
            tx_sh    <= tx_dout;
            uart_txd <= 1'b0;
         end else begin
            case (tx_state)
               TX_IDLE: uart_txd <= 1'b1;
               TX_START: begin
                  if (tx_tick) begin
                     tx_cnt   <= '0;
                     tx_bit   <= '0;
                     tx_state <= TX_DATA;
                     uart_txd <= tx_sh[0];
                  end else tx_cnt <= tx_cnt + DIV_W'(1);
               end
               TX_DATA: begin
                  if (tx_tick) begin
                     tx_cnt <= '0;
                     if (tx_bit == 3'd7) begin
                        tx_state <= TX_STOP;
                        uart_txd <= 1'b1;
                     end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                        uart_txd <= tx_sh[1];
                     end
                  end else tx_cnt <= tx_cnt + DIV_W'(1);
               end
               TX_STOP: begin
                  if (tx_tick) tx_state <= TX_IDLE;
                  else         tx_cnt   <= tx_cnt + DIV_W'(1);
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end

   // ---------------- RX ----------------
   rx_state_e        rx_state;
   logic             rx_s1, rx_s2, rx_prev;
   logic [DIV_W-1:0] rx_cnt, rx_div;
   logic [DIV_W:0]   rx_half;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_sh;
   logic             rx_stop_smp, rx_ovr_set, rx_ferr_set;

   assign rx_half     = ({1'b0, rx_div} + (DIV_W+1)'(1)) >> 1;
   assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == rx_div);
   assign rx_pop      = rd && (reg_sel == REG_DATA) && ~rx_empty;
   assign rx_push     = rx_stop_smp & rx_s2 & (~rx_full | rx_pop);
   assign rx_ovr_set  = rx_stop_smp & rx_s2 & rx_full & ~rx_pop;
   assign rx_ferr_set = rx_stop_smp & ~rx_s2;
   assign rx_valid    = ~rx_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rstn(rstn), .push(rx_push), .din(rx_sh), .pop(rx_pop),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_s1   <= uart_rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
                  rx_cnt   <= DIV_W'(1);
                  rx_div   <= divider;
               end
            end
            RX_START: begin
               // a start bit that is high again at its midpoint was a glitch
               if ({1'b0, rx_cnt} >= rx_half) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else rx_cnt <= rx_cnt + DIV_W'(1);
            end
            RX_DATA: begin
               if (rx_cnt == rx_div) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_s2, rx_sh[7:1]};
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else rx_cnt <= rx_cnt + DIV_W'(1);
            end
            RX_STOP: begin
               if (rx_stop_smp) rx_state <= RX_IDLE;
               else             rx_cnt   <= rx_cnt + DIV_W'(1);
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // ---------------- registers ----------------
   logic st_wr;
   assign st_wr = wr && (reg_sel == REG_STATUS);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         divider    <= DIV_W'(DIV_RESET);
         tx_ie      <= 1'b0;
         rx_ie      <= 1'b0;
         tx_ovf     <= 1'b0;
         frame_err  <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         if (wr && reg_sel == REG_DIVIDER) divider <= data_in[DIV_W-1:0];
         if (wr && reg_sel == REG_CTRL) {rx_ie, tx_ie} <= data_in[1:0];
         // set events take priority over a write-1-to-clear in the same cycle
         tx_ovf     <= (tx_push & tx_full & ~tx_pop) |
                       (tx_ovf & ~(st_wr & data_in[ST_TX_OVF]));
         frame_err  <= rx_ferr_set | (frame_err & ~(st_wr & data_in[ST_FRAME_ERR]));
         rx_overrun <= rx_ovr_set | (rx_overrun & ~(st_wr & data_in[ST_RX_OVERRUN]));
      end
   end

   assign status = {tx_ovf, frame_err, rx_overrun, rx_full, tx_full, rx_valid, tx_busy};
   assign irq    = (tx_ie & tx_empty & ~tx_busy) | (rx_ie & rx_valid);

   always_comb begin
      data_out = '0;
      case (reg_sel)
         REG_DATA:    data_out = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_dout};
         REG_STATUS:  data_out = {25'h0, status};
         REG_DIVIDER: data_out = {{(32-DIV_W){1'b0}}, divider};
         default:     data_out = {30'h0, rx_ie, tx_ie};
      endcase
   end

endmodule

// File: tb/tb_peri_uart_fifo.sv
// Directed bench for peri_uart_fifo at divider 7 (8 clocks per bit).
module tb_peri_uart_fifo;
   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  reg_sel;
   logic [1:0]  write_n;
   logic [1:0]  read_n;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        uart_rxd;
   logic        uart_txd;
   logic        irq;
`ifdef UART_FLOW_CTRL_EN
   logic        uart_rts;
   logic        uart_cts;
`endif

   int nvec = 0;
   int nerr = 0;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   peri_uart_fifo #(.TX_DEPTH(8), .RX_DEPTH(8), .DIV_W(12), .DIV_RESET(555)) dut (
      .clk(clk), .rstn(rstn), .reg_sel(reg_sel), .write_n(write_n), .read_n(read_n),
      .data_in(data_in), .data_out(data_out), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
`ifdef UART_FLOW_CTRL_EN
      .uart_rts(uart_rts), .uart_cts(uart_cts),
`endif
      .irq(irq)
   );

   task automatic bus_write(input logic [1:0] sel, input logic [31:0] d);
      @(negedge clk); reg_sel = sel; data_in = d; write_n = 2'b00;
      @(negedge clk); write_n = 2'b11;
   endtask

   task automatic bus_read(input logic [1:0] sel, output logic [31:0] d);
      @(negedge clk); reg_sel = sel; read_n = 2'b10; #1 d = data_out;
      @(negedge clk); read_n = 2'b11;
   endtask

   task automatic peek(input logic [1:0] sel, output logic [31:0] d);
      @(negedge clk); reg_sel = sel; #1 d = data_out;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(negedge clk); uart_rxd = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (8) @(negedge clk);
      end
      uart_rxd = stop;
      repeat (8) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      nvec++; if (uart_txd !== 1'b1) begin nerr++; $display("FAIL reset_txd got %b want 1", uart_txd); end
      nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq got %b want 0", irq); end
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL reset_status got %h want 0", rdata); end
      peek(2'd2, rdata);
      nvec++; if (rdata !== 32'd555) begin nerr++; $display("FAIL reset_divider got %0d want 555", rdata); end
      peek(2'd3, rdata);
      nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL reset_ctrl got %h want 0", rdata); end
      peek(2'd0, rdata);
      nvec++; if (rdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL reset_data got %h want ffffffff", rdata); end
      @(negedge clk); rstn = 1'b1;
   endtask

   task automatic test_ctrl_irq();
      bus_write(2'd3, 32'h3);
      #1;
      nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_tx_idle got %b want 1", irq); end
      peek(2'd3, rdata);
      nvec++; if (rdata !== 32'h3) begin nerr++; $display("FAIL ctrl_rb got %h want 3", rdata); end
      bus_write(2'd3, 32'h2);
      #1;
      nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_rx_only got %b want 0", irq); end
      bus_write(2'd3, 32'h0);
   endtask

   task automatic test_tx_frame();
      logic [7:0] b;
      logic exp_txd;
      logic exp_busy;
      b = 8'h55;
      bus_write(2'd2, 32'd7);
      peek(2'd2, rdata);
      nvec++; if (rdata !== 32'd7) begin nerr++; $display("FAIL divider_rb got %0d want 7", rdata); end
      bus_write(2'd0, {24'h0, b});
      reg_sel = 2'd1;
      for (int k = 0; k <= 80; k++) begin
         @(negedge clk); #1;
         if (k < 8)       exp_txd = 1'b0;
         else if (k < 72) exp_txd = b[(k-8)/8];
         else             exp_txd = 1'b1;
         exp_busy = (k < 80);
         nvec++; if (uart_txd !== exp_txd) begin nerr++; $display("FAIL tx_bit k=%0d got %b want %b", k, uart_txd, exp_txd); end
         nvec++; if (data_out[0] !== exp_busy) begin nerr++; $display("FAIL tx_busy k=%0d got %b want %b", k, data_out[0], exp_busy); end
      end
   endtask

   task automatic test_tx_fifo();
      bit done;
      @(negedge clk); reg_sel = 2'd0; write_n = 2'b00;
      for (int i = 0; i < 9; i++) begin
         data_in = 32'hA0 + i;
         @(negedge clk);
      end
      write_n = 2'b11;
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h05) begin nerr++; $display("FAIL tx_full_no_ovf got %h want 05", rdata); end
      bus_write(2'd0, 32'hEE);
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h45) begin nerr++; $display("FAIL tx_ovf_set got %h want 45", rdata); end
      bus_write(2'd1, 32'h40);
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h05) begin nerr++; $display("FAIL tx_ovf_clr got %h want 05", rdata); end
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk); #1;
         if (data_out[0] === 1'b0) done = 1'b1;
      end
      nvec++; if (!done) begin nerr++; $display("FAIL tx_drain got busy want idle within 3000 cycles"); end
   endtask

   task automatic test_rx_byte();
      send_frame(8'hA3, 1'b1);
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h02) begin nerr++; $display("FAIL rx_valid got %h want 02", rdata); end
      bus_write(2'd3, 32'h2);
      #1;
      nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_rx got %b want 1", irq); end
      bus_read(2'd0, rdata);
      nvec++; if (rdata !== 32'h0000_00A3) begin nerr++; $display("FAIL rx_data got %h want 000000a3", rdata); end
      #1;
      nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_rx_clear got %b want 0", irq); end
      bus_read(2'd0, rdata);
      nvec++; if (rdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL rx_empty_read got %h want ffffffff", rdata); end
      bus_write(2'd3, 32'h0);
   endtask

   task automatic test_rx_errors();
      send_frame(8'h3C, 1'b0);
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h20) begin nerr++; $display("FAIL frame_err got %h want 20", rdata); end
      bus_write(2'd1, 32'h20);
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL frame_err_clr got %h want 0", rdata); end
      @(negedge clk); uart_rxd = 1'b0;
      repeat (2) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (100) @(negedge clk);
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL glitch got %h want 0", rdata); end
      send_frame(8'h5A, 1'b1);
      bus_read(2'd0, rdata);
      nvec++; if (rdata !== 32'h5A) begin nerr++; $display("FAIL after_glitch got %h want 5a", rdata); end
   endtask

   task automatic test_rx_overrun();
      for (int i = 0; i < 9; i++) begin
         send_frame(8'h10 + 8'(i), 1'b1);
`ifdef UART_FLOW_CTRL_EN
         if (i == 5) begin
            nvec++; if (uart_rts !== 1'b0) begin nerr++; $display("FAIL rts_6 got %b want 0", uart_rts); end
         end
         if (i == 6) begin
            nvec++; if (uart_rts !== 1'b1) begin nerr++; $display("FAIL rts_7 got %b want 1", uart_rts); end
         end
`endif
      end
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h1A) begin nerr++; $display("FAIL rx_overrun got %h want 1a", rdata); end
      for (int i = 0; i < 8; i++) begin
         bus_read(2'd0, rdata);
         nvec++; if (rdata !== 32'h10 + i) begin nerr++; $display("FAIL rx_held[%0d] got %h want %h", i, rdata, 32'h10 + i); end
      end
      bus_read(2'd0, rdata);
      nvec++; if (rdata !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL rx_drained got %h want ffffffff", rdata); end
      bus_write(2'd1, 32'h10);
      peek(2'd1, rdata);
      nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL overrun_clr got %h want 0", rdata); end
   endtask

   task automatic test_reset_mid_tx();
      bus_write(2'd0, 32'h00);
      repeat (30) @(negedge clk);
      #1;
      nvec++; if (uart_txd !== 1'b0) begin nerr++; $display("FAIL mid_data_txd got %b want 0", uart_txd); end
      rstn = 1'b0;
      #1;
      nvec++; if (uart_txd !== 1'b1) begin nerr++; $display("FAIL abort_txd got %b want 1", uart_txd); end
      reg_sel = 2'd1; #1;
      nvec++; if (data_out !== 32'h0) begin nerr++; $display("FAIL abort_status got %h want 0", data_out); end
      reg_sel = 2'd2; #1;
      nvec++; if (data_out !== 32'd555) begin nerr++; $display("FAIL abort_divider got %0d want 555", data_out); end
      @(negedge clk); rstn = 1'b1;
   endtask

   initial begin
      reg_sel  = 2'd0;
      write_n  = 2'b11;
      read_n   = 2'b11;
      data_in  = 32'h0;
      uart_rxd = 1'b1;
`ifdef UART_FLOW_CTRL_EN
      uart_cts = 1'b0;
`endif
      test_reset();
      test_ctrl_irq();
      test_tx_frame();
      test_tx_fifo();
      test_rx_byte();
      test_rx_errors();
      test_rx_overrun();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/peri_uart_fifo.md
PERI_UART_FIFO -- requirements
Module: peri_uart_fifo

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, TX FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RX_DEPTH, default 8, RX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter DIV_W, default 12, baud divider width.
REQ-004 SHALL have parameter DIV_RESET, default 555, divider reset value (64 MHz / 115200 - 1).
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port reg_sel  in  2  register select: 0 DATA, 1 STATUS, 2 DIVIDER, 3 CTRL.
REQ-008 SHALL have port write_n  in  2  write strobe, active when != 2'b11.
REQ-009 SHALL have port read_n  in  2  read strobe, active when != 2'b11.
REQ-010 SHALL have port data_in  in  32  write data.
REQ-011 SHALL have port data_out  out  32  combinational read data for reg_sel.
REQ-012 SHALL have ports uart_rxd  in  1  and uart_txd  out  1, serial lines, idle high.
REQ-013 SHALL have port irq  out  1  level interrupt.

Function
REQ-014 SHALL complete every access in the strobe cycle (no wait states); write_n and read_n both active in one cycle is illegal.
REQ-015 SHALL, on DATA write, push data_in[7:0] to TX FIFO; if full, drop the byte and set sticky tx_ovf.
REQ-016 SHALL, on DATA read, return {24'h0, RX head} and pop in the same cycle; if empty, return 32'hFFFF_FFFF with no pop.
REQ-017 SHALL return STATUS = {25'h0, tx_ovf, frame_err, rx_overrun, rx_full, tx_full, rx_valid, tx_busy}; tx_busy = TX FIFO non-empty or frame in progress.
REQ-018 SHALL clear sticky bits [6:4] on STATUS write where the matching data_in bit is 1 (write-1-to-clear); a set event in the same cycle wins.
REQ-019 SHALL make DIVIDER R/W (D, DIV_W bits, zero-extended on read); bit period = D+1 clocks; D takes effect at next frame start.
REQ-020 SHALL make CTRL R/W bits [1:0] = {rx_ie, tx_ie}; irq = (tx_ie & TX FIFO empty & !tx_busy) | (rx_ie & rx_valid).
REQ-021 SHALL run TX FSM IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE, each state bit lasting D+1 clocks; FIFO popped on IDLE->START; STOP goes directly to START if FIFO non-empty (back-to-back frames).
REQ-022 SHALL synchronise uart_rxd through 2 flops; RX FSM IDLE -> START on falling edge; re-sample at (D+1)>>1 clocks, return to IDLE if high (glitch).
REQ-023 SHALL sample 8 data bits then stop bit at D+1 intervals from start-bit midpoint.
REQ-024 SHALL push byte at stop-bit sample if stop=1 and FIFO not full; stop=0 sets frame_err and discards; FIFO full sets rx_overrun and discards.
REQ-025 SHALL allow simultaneous push and pop on either FIFO, including when full (RX: pop frees entry first, byte accepted).

Reset
REQ-026 SHALL on rstn low asynchronously: FIFOs empty, both FSMs IDLE, uart_txd=1, divider=DIV_RESET, CTRL=0, sticky bits 0, irq=0.
REQ-027 SHALL abort any frame mid-transmission on reset; uart_txd returns high immediately.

Configuration
REQ-028 SHALL, with UART_FLOW_CTRL_EN defined, add ports uart_rts out 1 and uart_cts in 1 (CTS 2-flop synchronised).
REQ-029 SHALL, with UART_FLOW_CTRL_EN, drive uart_rts=1 when RX count >= RX_DEPTH-1, else 0 (0 also in reset); TX not leave IDLE/STOP into START while cts=1; frame in progress completes.
REQ-030 SHALL, without UART_FLOW_CTRL_EN, omit both ports and transmit unconditionally.

Structure
REQ-031 SHALL place register-select constants, STATUS bit indices and TX/RX state encodings in shared package uart_pkg.
REQ-032 SHALL instantiate sub-module sync_fifo (params WIDTH, DEPTH; push, pop, full, empty, count) twice.

Verification
REQ-033 SHALL test D=7: write 0x55 -> txd low 8 clocks, bits 1,0,1,0,1,0,1,0 each 8 clocks, stop high; tx_busy falls after 80 clocks.
REQ-034 SHALL test TX_DEPTH=8: write 9 bytes back-to-back while idle -> first pops immediately, 8 queued, none dropped; 10th write while full -> tx_ovf=1; STATUS write 0x40 clears it.
REQ-035 SHALL test drive 0xA3 at D=7 -> rx_valid=1, DATA read returns 0x000000A3, next read 0xFFFFFFFF.
REQ-036 SHALL test frame with stop bit 0 -> frame_err=1, rx_valid stays 0; 2-clock low glitch -> no frame.
REQ-037 SHALL test 9 frames unread into RX_DEPTH=8 -> 8 held, rx_overrun=1; with UART_FLOW_CTRL_EN uart_rts=1 after 7th byte.
REQ-038 SHALL test rstn low mid-DATA state -> txd=1, STATUS=0, divider=DIV_RESET on same edge.
